// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller
//
// Purpose:
//   Owns the fetch program counter and keeps exactly one instruction-bus read
//   in flight at a time.  Fetched words go to decode, or are parked while
//   decode stalls.  The controller also follows control-flow redirects.
//
//   Redirects are taken in priority order:
//     eret (epc) > exc_oc (EXC_ADDR) > pf (pf_target) > bp_take (bp_target).
//   A predicted-taken branch whose target equals the current pc changes
//   nothing, so it is not treated as a redirect.
//
//   A response that belongs to a fetch made obsolete by a redirect is
//   swallowed through a cancel flag.  It never reaches decode.
//
// Optional feature:
//   FETCH_CTRL_PERF_EN -- when defined, adds the redirect_cnt output.  This
//   is a free-running (wrapping) count of accepted redirects.  When the macro
//   is undefined, the port and the counter do not exist.
//
// Parameters:
//   RESET_ADDR  first fetch address after reset
//   EXC_ADDR    exception entry address
//
// Ports:
//   clk            clock, all state on rising edge
//   resetn         asynchronous active-low reset
//   stall          decode not ready; the delivered instruction must be held
//   bp_take        branch predicted taken, bp_target = predicted target
//   pf             prediction failed,      pf_target = corrected target
//   exc_oc         exception occurred (go to EXC_ADDR)
//   eret           exception return,       epc = return address
//   inst_req       fetch request to the instruction bus
//   inst_addr      fetch word address
//   inst_addr_ok   bus accepted the request this cycle
//   inst_data_ok   bus returns read data this cycle, inst_rdata = the word
//   if_valid       an instruction is presented to decode this cycle
//   if_pc          address of the presented instruction
//   if_inst        the presented instruction word
//   redirect_cnt   accepted-redirect counter (FETCH_CTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'hbfc0_0000,
  parameter logic [31:0] EXC_ADDR   = 32'hbfc0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        bp_take,
  input  logic [31:0] bp_target,
  input  logic        pf,
  input  logic [31:0] pf_target,
  input  logic        exc_oc,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;          // address of the instruction being fetched/held
  logic        cancel_reg;      // the outstanding response is stale
  logic        boot_reg;        // first post-reset cycle has elapsed
  logic        inst_req_reg;
  logic [31:0] hold_inst_reg;   // word parked while decode stalls

  logic        redirect;
  logic [31:0] redirect_target;
  logic        deliver_direct;
  logic        advance;

  // ---------------------------------------------------------------------------
  // Redirect arbitration.  The branch-prediction case is qualified against
  // pc_reg, so a predicted target equal to the current pc is ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    redirect        = 1'b1;
    redirect_target = pc_reg;
    if (eret) begin
      redirect_target = epc;
    end else if (exc_oc) begin
      redirect_target = EXC_ADDR;
    end else if (pf) begin
      redirect_target = pf_target;
    end else if (bp_take && (bp_target != pc_reg)) begin
      redirect_target = bp_target;
    end else begin
      redirect        = 1'b0;
    end
  end

  // Response goes straight to decode: it is live, not overridden by a
  // redirect in the same cycle, and decode can take it now.
  assign deliver_direct = (state_reg == S_WAIT) && inst_data_ok && !cancel_reg
                          && !redirect && !stall;

  // pc steps forward once for every instruction decode actually consumes.
  assign advance = deliver_direct || ((state_reg == S_HOLD) && !stall);

  // ---------------------------------------------------------------------------
  // Control FSM.  IDLE lasts one full cycle after reset release (boot_reg).
  // As a result, the first request appears on the second rising edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      pc_reg        <= RESET_ADDR;
      cancel_reg    <= 1'b0;
      boot_reg      <= 1'b0;
      inst_req_reg  <= 1'b0;
      hold_inst_reg <= 32'h0;
    end else begin
      // pc: a redirect always wins over sequential advance.
      if (redirect) begin
        pc_reg <= redirect_target;
      end else if (advance) begin
        pc_reg <= pc_reg + 32'd4;   // wraps modulo 2^32
      end

      case (state_reg)
        S_IDLE: begin
          boot_reg <= 1'b1;
          if (boot_reg) begin
            state_reg    <= S_REQ;
            inst_req_reg <= 1'b1;
          end
        end

        S_REQ: begin
          // Before acceptance, the address change needs only the pc update.
          // Once accepted, the in-flight fetch is stale if we redirected.
          if (inst_addr_ok) begin
            state_reg    <= S_WAIT;
            inst_req_reg <= 1'b0;
            cancel_reg   <= redirect;
          end
        end

        S_WAIT: begin
          if (inst_data_ok) begin
            cancel_reg <= 1'b0;
            if (cancel_reg || redirect || !stall) begin
              // Delivered, discarded as stale, or overridden: fetch again.
              state_reg    <= S_REQ;
              inst_req_reg <= 1'b1;
            end else begin
              hold_inst_reg <= inst_rdata;
              state_reg     <= S_HOLD;
            end
          end else if (redirect) begin
            cancel_reg <= 1'b1;
          end
        end

        S_HOLD: begin
          // A redirect drops the parked word.  The pc already moved above.
          if (redirect || !stall) begin
            state_reg    <= S_REQ;
            inst_req_reg <= 1'b1;
          end
        end

        default: begin
          state_reg    <= S_IDLE;
          inst_req_reg <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.  The bus side comes from registers only.  if_valid/if_inst must
  // show a word in the same cycle it returns from the bus.  They therefore
  // include the direct-delivery path.
  // ---------------------------------------------------------------------------
  assign inst_req  = inst_req_reg;
  assign inst_addr = pc_reg;
  assign if_pc     = pc_reg;
  assign if_valid  = (state_reg == S_HOLD) || deliver_direct;

  always_comb begin
    if_inst = 32'h0;
    if (state_reg == S_HOLD) begin
      if_inst = hold_inst_reg;
    end else if (deliver_direct) begin
      if_inst = inst_rdata;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] redirect_cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_cnt_reg <= 32'h0;
    end else if (redirect) begin
      redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- directed, self-checking bench for fetch_ctrl
//
// Inputs are driven just after the falling edge.  Outputs are sampled 1 ns
// later, still well away from the rising edge.  Every segment of the stimulus
// ends right after a falling edge, with all request inputs idle.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        bp_take;
  logic [31:0] bp_target;
  logic        pf;
  logic [31:0] pf_target;
  logic        exc_oc;
  logic        eret;
  logic [31:0] epc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall        (stall),
    .bp_take      (bp_take),
    .bp_target    (bp_target),
    .pf           (pf),
    .pf_target    (pf_target),
    .exc_oc       (exc_oc),
    .eret         (eret),
    .epc          (epc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef FETCH_CTRL_PERF_EN
    check(tag, redirect_cnt, exp_cnt);
`endif
  endtask

  task automatic idle_in;
    stall        = 1'b0;
    bp_take      = 1'b0;
    bp_target    = 32'h0;
    pf           = 1'b0;
    pf_target    = 32'h0;
    exc_oc       = 1'b0;
    eret         = 1'b0;
    epc          = 32'h0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
  endtask

  // One undisturbed fetch.  The request is accepted immediately, and data
  // returns on the next cycle with decode ready.
  task automatic fetch(input logic [31:0] a, input logic [31:0] w);
    inst_addr_ok = 1'b1;
    #1;
    check("fetch_req", inst_req, 32'd1);
    check("fetch_addr", inst_addr, a);
    check("fetch_novalid", if_valid, 32'd0);
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = w;
    #1;
    check("fetch_valid", if_valid, 32'd1);
    check("fetch_pc", if_pc, a);
    check("fetch_inst", if_inst, w);
    check("fetch_wait_noreq", inst_req, 32'd0);
    $display("fetch addr=%h inst=%h", a, w);
    @(negedge clk);
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
  endtask

  // Cross one clock with idle inputs, then expect a request at exp_addr.
  task automatic expect_req(input string tag, input logic [31:0] exp_addr);
    @(negedge clk);
    idle_in();
    #1;
    check({tag, "_req"}, inst_req, 32'd1);
    check(tag, inst_addr, exp_addr);
    $display("redirect %s addr=%h", tag, inst_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle_in();

    // Values held while reset is asserted.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", inst_req, 32'd0);
    check("rst_valid", if_valid, 32'd0);
    check("rst_pc", if_pc, 32'hbfc0_0000);
    check("rst_inst", if_inst, 32'h0);
    chk_cnt("rst_cnt");

    // Release: one IDLE cycle, then a request on the second rising edge.
    resetn = 1'b1;
    @(negedge clk);
    #1;
    check("idle_noreq", inst_req, 32'd0);
    @(negedge clk);

    // Three sequential fetches.
    fetch(32'hbfc0_0000, 32'h1111_0000);
    fetch(32'hbfc0_0004, 32'h1111_0004);
    fetch(32'hbfc0_0008, 32'h1111_0008);

    // Priority: all redirect sources at once in REQ without acceptance.
    eret = 1'b1; epc = 32'h8000_0100; exc_oc = 1'b1;
    pf = 1'b1; pf_target = 32'ha000_0040; bp_take = 1'b1; bp_target = 32'hbfc0_0200;
    #1;
    check("prio_cur_addr", inst_addr, 32'hbfc0_000c);
    exp_cnt++;
    expect_req("prio_eret", 32'h8000_0100);
    chk_cnt("cnt_eret");

    exc_oc = 1'b1; pf = 1'b1; pf_target = 32'ha000_0040;
    bp_take = 1'b1; bp_target = 32'hbfc0_0200;
    exp_cnt++;
    expect_req("prio_exc", 32'hbfc0_0380);

    pf = 1'b1; pf_target = 32'ha000_0040; bp_take = 1'b1; bp_target = 32'hbfc0_0200;
    exp_cnt++;
    expect_req("prio_pf", 32'ha000_0040);

    // A branch prediction to the current pc is not a redirect.
    bp_take = 1'b1; bp_target = 32'ha000_0040;
    expect_req("bp_same", 32'ha000_0040);
    chk_cnt("cnt_bp_same");

    bp_take = 1'b1; bp_target = 32'hbfc0_0200;
    exp_cnt++;
    expect_req("bp_new", 32'hbfc0_0200);
    chk_cnt("cnt_bp_new");

    fetch(32'hbfc0_0200, 32'h2222_0200);

    // pf while waiting for data: the late response is swallowed.
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    pf = 1'b1; pf_target = 32'hbfc0_1000;
    #1;
    check("pfw_valid0", if_valid, 32'd0);
    exp_cnt++;
    @(negedge clk);
    pf = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
    #1;
    check("pfw_discard", if_valid, 32'd0);
    check("pfw_noreq", inst_req, 32'd0);
    expect_req("pfw_target", 32'hbfc0_1000);

    // Redirect together with the data: discarded, target next cycle.
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h3333_1000;
    pf = 1'b1; pf_target = 32'hbfc0_2000;
    #1;
    check("coinc_discard", if_valid, 32'd0);
    exp_cnt++;
    expect_req("coinc_target", 32'hbfc0_2000);

    // Redirect in the acceptance cycle: the response is stale.
    inst_addr_ok = 1'b1; pf = 1'b1; pf_target = 32'hbfc0_3000;
    #1;
    check("acc_cur_addr", inst_addr, 32'hbfc0_2000);
    exp_cnt++;
    @(negedge clk);
    idle_in();
    inst_data_ok = 1'b1; inst_rdata = 32'h4444_2000;
    #1;
    check("acc_noreq", inst_req, 32'd0);
    check("acc_discard", if_valid, 32'd0);
    expect_req("acc_target", 32'hbfc0_3000);

    fetch(32'hbfc0_3000, 32'h5555_3000);

    // Redirect while holding: the parked word is dropped.
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h6666_3004; stall = 1'b1;
    #1;
    check("hold_entry_valid0", if_valid, 32'd0);
    @(negedge clk);
    inst_data_ok = 1'b0;
    #1;
    check("hold_valid", if_valid, 32'd1);
    check("hold_pc", if_pc, 32'hbfc0_3004);
    check("hold_inst", if_inst, 32'h6666_3004);
    pf = 1'b1; pf_target = 32'hffff_fffc;
    exp_cnt++;
    @(negedge clk);
    idle_in();
    #1;
    check("holdrd_valid0", if_valid, 32'd0);
    check("holdrd_req", inst_req, 32'd1);
    check("holdrd_addr", inst_addr, 32'hffff_fffc);

    // pc wraps from the top word to zero.
    fetch(32'hffff_fffc, 32'h7777_fffc);
    fetch(32'h0000_0000, 32'h7777_0000);
    chk_cnt("cnt_total");

    // Reset during WAIT: outputs return to reset values immediately.
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    check("mrst_req", inst_req, 32'd0);
    check("mrst_valid", if_valid, 32'd0);
    check("mrst_pc", if_pc, 32'hbfc0_0000);
    check("mrst_inst", if_inst, 32'h0);
    exp_cnt = 0;
    chk_cnt("mrst_cnt");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    check("mrst_idle", inst_req, 32'd0);
    @(negedge clk);

    // Stall on return: held for three cycles, then consumed exactly once.
    inst_addr_ok = 1'b1;
    #1;
    check("stall_addr", inst_addr, 32'hbfc0_0000);
    @(negedge clk);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h8888_0000; stall = 1'b1;
    #1;
    check("stall_entry_valid0", if_valid, 32'd0);
    @(negedge clk);
    inst_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", if_valid, 32'd1);
      check("stall_pc", if_pc, 32'hbfc0_0000);
      check("stall_inst", if_inst, 32'h8888_0000);
      check("stall_noreq", inst_req, 32'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    check("stall_release_valid", if_valid, 32'd1);
    expect_req("stall_next", 32'hbfc0_0004);
    check("stall_once", if_valid, 32'd0);
    fetch(32'hbfc0_0004, 32'h8888_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
